// File: rtl/cr_sa_counter_bank_p_pkg.sv
// cr_sa_genPKG: shared types and limits for the stats-aggregator counter bank
package cr_sa_genPKG;
    localparam int SA_SEL_W      = 10;
    localparam int SA_MAX_EVENTS = 1024;
    typedef struct packed {
        logic                cnt_en;
        logic                sat_mode;
        logic [SA_SEL_W-1:0] event_sel;
    } sa_gen_ctrl_t;
endpackage

// File: rtl/cr_sa_counter_p.sv
// cr_sa_counter_p: one event-select counter with wrap/saturate, sticky overflow, snapshot and optional threshold irq (CR_SA_THRESH_IRQ_EN)
module cr_sa_counter_p
    import cr_sa_genPKG::*;
#(
    parameter int N_EV  = 1024,
    parameter int CNT_W = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_EV-1:0]   i_events,
    input  sa_gen_ctrl_t      i_ctrl,
    input  logic              i_snap,
    input  logic              i_clr,
    input  logic              i_snap_clr,
`ifdef CR_SA_THRESH_IRQ_EN
    input  logic [CNT_W-1:0]  i_thresh,
    output logic              o_irq,
`endif
    output logic [CNT_W-1:0]  o_count,
    output logic [CNT_W-1:0]  o_snapshot,
    output logic              o_ovf
);
    logic [SA_MAX_EVENTS-1:0] w_pad;
    logic [CNT_W-1:0]         r_cnt, r_snapshot, w_next;
    logic                     r_ovf, w_inc, w_max;

    // zero-pad the event vector so selects beyond the configured event count read as no event
    always_comb begin
        w_pad             = '0;
        w_pad[N_EV-1:0]   = i_events;
    end

    assign w_inc  = i_ctrl.cnt_en & w_pad[i_ctrl.event_sel];
    assign w_max  = &r_cnt;
    assign w_next = !w_inc ? r_cnt : !w_max ? r_cnt + 1'b1 : i_ctrl.sat_mode ? r_cnt : '0;

    // snap_clear > clear > normal count; snapshots always capture the pre-increment value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_snapshot <= '0;
            r_ovf      <= 1'b0;
        end else if (i_snap_clr) begin
            r_snapshot <= r_cnt;
            r_cnt      <= {{(CNT_W-1){1'b0}}, w_inc};
            r_ovf      <= 1'b0;
        end else if (i_clr) begin
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_cnt      <= w_next;
            r_ovf      <= r_ovf | (w_inc & w_max);
            if (i_snap) r_snapshot <= r_cnt;
        end
    end

`ifdef CR_SA_THRESH_IRQ_EN
    logic r_irq;

    // sticky irq on the update that carries the count from below to at/above a nonzero threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else if (i_snap_clr | i_clr) r_irq <= 1'b0;
        else if (i_thresh != '0 && w_next >= i_thresh && r_cnt < i_thresh) r_irq <= 1'b1;
    end

    assign o_irq = r_irq;
`endif

    assign o_count    = r_cnt;
    assign o_snapshot = r_snapshot;
    assign o_ovf      = r_ovf;
endmodule

// File: rtl/cr_sa_counter_bank_p.sv
// cr_sa_counter_bank_p: registered stat events feeding N_CNT select counters with snap/clear control; threshold irq ports under CR_SA_THRESH_IRQ_EN
module cr_sa_counter_bank_p
    import cr_sa_genPKG::*;
#(
    parameter int N_CNT = 64,
    parameter int N_GRP = 16,
    parameter int GRP_W = 64,
    parameter int CNT_W = 50
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_GRP*GRP_W-1:0]   stat_events,
    input  sa_gen_ctrl_t             regs_sa_ctrl [N_CNT],
    input  logic                     regs_sa_snap,
    input  logic                     regs_sa_clear_live,
    input  logic                     regs_sa_snap_clear,
`ifdef CR_SA_THRESH_IRQ_EN
    input  logic [CNT_W-1:0]         regs_sa_thresh [N_CNT],
    output logic [N_CNT-1:0]         sa_thresh_irq,
`endif
    output logic [CNT_W-1:0]         sa_count [N_CNT],
    output logic [CNT_W-1:0]         sa_snapshot [N_CNT],
    output logic [N_CNT-1:0]         sa_ovf,
    output logic                     sa_snap_done
);
    localparam int N_EV = N_GRP * GRP_W;

    logic [N_EV-1:0] r_events;
    logic [2:0]      r_lvl, r_pulse, w_lvl;
    logic            r_upd, r_done, w_snap, w_clr, w_sc;

    assign w_lvl  = {regs_sa_snap_clear, regs_sa_clear_live, regs_sa_snap};
    assign w_sc   = r_pulse[2] | (r_pulse[0] & r_pulse[1]);
    assign w_snap = r_pulse[0] & ~w_sc;
    assign w_clr  = r_pulse[1] & ~w_sc;

    // event pipeline stage, rising-edge pulses, and snap_done one cycle after the snapshot becomes visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_events <= '0;
            r_lvl    <= '0;
            r_pulse  <= '0;
            r_upd    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_events <= stat_events;
            r_lvl    <= w_lvl;
            r_pulse  <= w_lvl & ~r_lvl;
            r_upd    <= w_snap | w_sc;
            r_done   <= r_upd;
        end
    end

    assign sa_snap_done = r_done;

    for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
        cr_sa_counter_p #(.N_EV(N_EV), .CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_events   (r_events),
            .i_ctrl     (regs_sa_ctrl[i]),
            .i_snap     (w_snap),
            .i_clr      (w_clr),
            .i_snap_clr (w_sc),
`ifdef CR_SA_THRESH_IRQ_EN
            .i_thresh   (regs_sa_thresh[i]),
            .o_irq      (sa_thresh_irq[i]),
`endif
            .o_count    (sa_count[i]),
            .o_snapshot (sa_snapshot[i]),
            .o_ovf      (sa_ovf[i])
        );
    end
endmodule

// File: tb/tb_cr_sa_counter_bank_p.sv
// tb_cr_sa_counter_bank_p: scoreboard bench for the stats-aggregator counter bank
module tb_cr_sa_counter_bank_p;
    import cr_sa_genPKG::*;
    localparam int N_CNT = 2, N_GRP = 15, GRP_W = 64, CNT_W = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N_GRP*GRP_W-1:0] ev = '0;
    sa_gen_ctrl_t           ctrl [N_CNT];
    logic                   snap = 1'b0, clr = 1'b0, sc = 1'b0;
    logic [CNT_W-1:0]       cnt [N_CNT];
    logic [CNT_W-1:0]       snp [N_CNT];
    logic [N_CNT-1:0]       ovf;
    logic                   done;
`ifdef CR_SA_THRESH_IRQ_EN
    logic [CNT_W-1:0]       thr [N_CNT];
    logic [N_CNT-1:0]       irq;
`endif

    cr_sa_counter_bank_p #(.N_CNT(N_CNT), .N_GRP(N_GRP), .GRP_W(GRP_W), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stat_events        (ev),
        .regs_sa_ctrl       (ctrl),
        .regs_sa_snap       (snap),
        .regs_sa_clear_live (clr),
        .regs_sa_snap_clear (sc),
`ifdef CR_SA_THRESH_IRQ_EN
        .regs_sa_thresh     (thr),
        .sa_thresh_irq      (irq),
`endif
        .sa_count           (cnt),
        .sa_snapshot        (snp),
        .sa_ovf             (ovf),
        .sa_snap_done       (done)
    );

    int          cyc = 0;
    string       nm_q[$];
    int          k_q[$];
    logic [63:0] e_q[$];
    int          done_q[$];
    int          n_chk = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] act(int k);
        case (k)
            0: return 64'(cnt[0]);
            1: return 64'(snp[0]);
            2: return 64'(ovf[0]);
            3: return 64'(cnt[1]);
            4: return 64'(ovf[1]);
            5: return 64'(done);
            6: return 64'(done_q.size());
`ifdef CR_SA_THRESH_IRQ_EN
            7: return 64'(irq[0]);
`endif
            default: return 64'hdead;
        endcase
    endfunction

    // monitor: snap_done pulses are matched against expected cycles; queued value checks are popped and compared
    always @(negedge clk) begin
        int exp_c;
        string n;
        int k;
        logic [63:0] e, a;
        if (done) begin
            n_chk++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL snap_done_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_c = done_q.pop_front();
                if (exp_c != cyc) begin
                    n_err++;
                    $display("FAIL snap_done_cycle: got cycle %0d, expected %0d", cyc, exp_c);
                end
            end
        end
        while (nm_q.size() > 0) begin
            n = nm_q.pop_front();
            k = k_q.pop_front();
            e = e_q.pop_front();
            a = act(k);
            n_chk++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %0d, expected %0d", n, a, e);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(string n, int k, logic [63:0] v);
        nm_q.push_back(n);
        k_q.push_back(k);
        e_q.push_back(v);
    endtask

    task automatic events(int b, int n);
        ev[b] = 1'b1;
        tick(n);
        ev[b] = 1'b0;
    endtask

    // one-cycle high on the selected command levels, optionally with a same-cycle event on bit b
    task automatic cmd(bit s, bit c, bit x, bit e_on, int b);
        snap = s;
        clr  = c;
        sc   = x;
        if (e_on) ev[b] = 1'b1;
        if (s | x) done_q.push_back(cyc + 3);
        tick(1);
        ev   = '0;
        snap = 1'b0;
        clr  = 1'b0;
        sc   = 1'b0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ctrl[0] = '{cnt_en: 1'b1, sat_mode: 1'b0, event_sel: 10'd70};
        ctrl[1] = '{cnt_en: 1'b1, sat_mode: 1'b0, event_sel: 10'd1023};
`ifdef CR_SA_THRESH_IRQ_EN
        thr[0] = '0;
        thr[1] = '0;
`endif
        tick(2);
        expect_v("rst_cnt0", 0, 0);
        expect_v("rst_snap0", 1, 0);
        expect_v("rst_ovf0", 2, 0);
        expect_v("rst_cnt1", 3, 0);
        expect_v("rst_done", 5, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        events(70, 5);
        expect_v("t1_latency", 0, 4);
        tick(1);
        expect_v("t1_count5", 0, 5);

        events(70, 5);
        tick(1);
        expect_v("t3_count10", 0, 10);
        cmd(1, 0, 0, 1, 70);
        expect_v("t3_snapshot", 1, 10);
        expect_v("t3_count", 0, 11);

        cmd(0, 1, 0, 0, 0);
        expect_v("t4_clear", 0, 0);
        events(70, 10);
        tick(1);
        cmd(0, 1, 0, 1, 70);
        expect_v("t4_clear_wins", 0, 0);
        expect_v("t4_clear_ovf", 2, 0);
        events(70, 10);
        tick(1);
        cmd(0, 0, 1, 1, 70);
        expect_v("t4_sc_snapshot", 1, 10);
        expect_v("t4_sc_count", 0, 1);
        cmd(1, 1, 0, 1, 70);
        expect_v("t4_snapclr_snapshot", 1, 1);
        expect_v("t4_snapclr_count", 0, 1);

        cmd(0, 1, 0, 0, 0);
        events(70, 255);
        tick(1);
        expect_v("t2_max", 0, 255);
        expect_v("t2_max_ovf", 2, 0);
        events(70, 1);
        tick(1);
        expect_v("t2_wrap", 0, 0);
        expect_v("t2_wrap_ovf", 2, 1);
        events(70, 2);
        tick(1);
        expect_v("t2_after_wrap", 0, 2);
        expect_v("t2_ovf_sticky", 2, 1);
        cmd(0, 1, 0, 0, 0);
        expect_v("t2_ovf_cleared", 2, 0);
        ctrl[0].sat_mode = 1'b1;
        events(70, 255);
        tick(1);
        expect_v("t2_sat_max_ovf", 2, 0);
        events(70, 4);
        tick(1);
        expect_v("t2_sat_hold", 0, 255);
        expect_v("t2_sat_ovf", 2, 1);
        cmd(1, 0, 0, 0, 0);
        expect_v("t2_snap_keeps_ovf", 2, 1);
        expect_v("t2_snap_val", 1, 255);

        ctrl[0].cnt_en = 1'b0;
        tick(1);
        ev = '1;
        tick(3);
        ev = '0;
        tick(2);
        expect_v("t5_disabled_hold", 0, 255);
        expect_v("t5_sel1023_none", 3, 0);
        ctrl[1].event_sel = 10'd959;
        tick(1);
        events(959, 2);
        tick(1);
        expect_v("t5_sel959", 3, 2);
        cmd(0, 0, 1, 1, 70);
        expect_v("t5_dis_sc_snapshot", 1, 255);
        expect_v("t5_dis_sc_count", 0, 0);
        expect_v("t5_dis_sc_ovf", 2, 0);

        ctrl[0] = '{cnt_en: 1'b1, sat_mode: 1'b0, event_sel: 10'd70};
        tick(1);
`ifdef CR_SA_THRESH_IRQ_EN
        thr[0] = 8'd4;
        tick(1);
        events(70, 3);
        tick(1);
        expect_v("t6_irq_below", 7, 0);
        events(70, 1);
        tick(1);
        expect_v("t6_irq_set", 7, 1);
        expect_v("t6_count4", 0, 4);
        cmd(0, 1, 0, 0, 0);
        expect_v("t6_irq_cleared", 7, 0);
        thr[0] = '0;
        tick(1);
`endif

        events(70, 3);
        tick(1);
        expect_v("rr_count3", 0, 3);
        snap     = 1'b1;
        ev[70]   = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        expect_v("rr_cnt0", 0, 0);
        expect_v("rr_snap0", 1, 0);
        expect_v("rr_ovf0", 2, 0);
        expect_v("rr_cnt1", 3, 0);
        expect_v("rr_done", 5, 0);
`ifdef CR_SA_THRESH_IRQ_EN
        expect_v("rr_irq0", 7, 0);
`endif
        tick(2);
        ev    = '0;
        rst_n = 1'b1;
        done_q.push_back(cyc + 3);
        tick(1);
        snap = 1'b0;
        tick(4);
        expect_v("rr_resnap_val", 1, 0);
        expect_v("rr_count_after", 0, 0);

        tick(3);
        expect_v("done_q_drained", 6, 0);
        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
